// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer.
// Drives datapath enables, memory req/ready and traps.
module multicycle_ctrl #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        branch,
  input  logic        jump,
  input  logic        is_system,
  input  logic        illegal,
  input  logic        branch_taken,
  input  logic        mem_ready,
  input  logic        trap_clr,
  output logic        ir_en,
  output logic        mdr_en,
  output logic        pc_en,
  output logic        pc_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        rf_we,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [TIMEOUT_W-1:0] LAST =
    TIMEOUT_W'(TIMEOUT - 1);

  state_t cur, nxt;

  logic [TIMEOUT_W-1:0] cnt;
  logic l_rw, l_mr, l_mw, l_br, l_j;
  logic latch, cnt_clr, cnt_inc, retire;
  logic cause_set, cause_clr;
  logic [1:0] cause_nxt;
  logic timed_out;

  assign timed_out = (cnt == LAST);
  assign state     = cur;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // Memory-wait counter, shared by FETCH and MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + 1'b1;
  end

  // Decoder controls captured once per instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_rw <= 1'b0;
      l_mr <= 1'b0;
      l_mw <= 1'b0;
      l_br <= 1'b0;
      l_j  <= 1'b0;
    end else if (latch) begin
      l_rw <= reg_write;
      l_mr <= mem_read;
      l_mw <= mem_write;
      l_br <= branch;
      l_j  <= jump;
    end
  end

  // Trap cause held while in TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         trap_cause <= 2'b00;
    else if (cause_set) trap_cause <= cause_nxt;
    else if (cause_clr) trap_cause <= 2'b00;
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + 32'd1;
  end

  // Next state and datapath controls
  always_comb begin
    nxt       = cur;
    ir_en     = 1'b0;
    mdr_en    = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    rf_we     = 1'b0;
    trap      = 1'b0;
    latch     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    retire    = 1'b0;
    cause_set = 1'b0;
    cause_clr = 1'b0;
    cause_nxt = 2'b00;
    unique case (cur)
      S_IDLE: begin
        if (run) nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_en   = 1'b1;
          cnt_clr = 1'b1;
          nxt     = S_DECODE;
        end else if (timed_out) begin
          cnt_clr   = 1'b1;
          cause_set = 1'b1;
          cause_nxt = 2'b10;
          nxt       = S_TRAP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DECODE: begin
        latch = 1'b1;
        if (illegal) begin
          cause_set = 1'b1;
          cause_nxt = 2'b01;
          nxt       = S_TRAP;
        end else if (is_system) begin
          cause_set = 1'b1;
          cause_nxt = 2'b11;
          nxt       = S_TRAP;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (l_mr || l_mw) begin
          nxt = S_MEM;
        end else if (l_rw) begin
          nxt = S_WB;
        end else begin
          pc_en  = 1'b1;
          pc_sel = (l_br & branch_taken) | l_j;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = l_mw;
        if (mem_ready) begin
          cnt_clr = 1'b1;
          if (l_mw) begin
            pc_en  = 1'b1;
            retire = 1'b1;
          end else begin
            mdr_en = 1'b1;
            nxt    = S_WB;
          end
        end else if (timed_out) begin
          cnt_clr   = 1'b1;
          cause_set = 1'b1;
          cause_nxt = 2'b10;
          nxt       = S_TRAP;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_WB: begin
        rf_we  = 1'b1;
        pc_en  = 1'b1;
        pc_sel = l_j;
        retire = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
        if (trap_clr) begin
          cause_clr = 1'b1;
          nxt       = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
    if (retire) nxt = run ? S_FETCH : S_IDLE;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random instruction
// stream against a per-cycle expectation model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        reg_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        is_system = 1'b0;
  logic        illegal = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        trap_clr = 1'b0;
  logic        ir_en, mdr_en, pc_en, pc_sel;
  logic        mem_req, mem_we, addr_sel, rf_we;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
  logic [31:0] instret;

  int total = 0;
  int bad = 0;
  logic [31:0] m_instret = '0;
  bit m_idle = 1'b1;

  typedef struct {
    logic [2:0] st;
    bit rdy, ir, mdr, pce, pcs;
    bit req, we, as, rfw;
  } cyc_t;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch),
    .jump(jump), .is_system(is_system),
    .illegal(illegal), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .trap_clr(trap_clr),
    .ir_en(ir_en), .mdr_en(mdr_en), .pc_en(pc_en),
    .pc_sel(pc_sel), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel),
    .rf_we(rf_we), .trap(trap),
    .trap_cause(trap_cause), .state(state),
    .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    run = 1'b1;
    mem_ready = 1'b1;
    trap_clr = 1'b1;
    illegal = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({state, ir_en, mdr_en, pc_en, pc_sel, mem_req,
         mem_we, addr_sel, rf_we, trap, trap_cause}
        !== 14'd0) begin
      bad++;
      $display("FAIL reset_outs got st=%0d req=%b trap=%b",
               state, mem_req, trap);
    end
    total++;
    if (instret !== 32'd0) begin
      bad++;
      $display("FAIL reset_instret got=%h exp=0", instret);
    end
    run = 1'b0;
    mem_ready = 1'b0;
    trap_clr = 1'b0;
    illegal = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_instr_stream();
    cyc_t q[$];
    cyc_t c;
    int kind, fw, mw;
    bit tk, rw, mr, ms, br, jp, lrun, rrun;
    logic [13:0] got, exp;
    for (int k = 0; k < 40; k++) begin
      tk = 1'b0;
      mw = 0;
      if (k == 0) begin kind = 0; fw = 0; end
      else if (k == 1) begin kind = 1; fw = 0; mw = 3; end
      else if (k == 2) begin kind = 3; fw = 0; tk = 1; end
      else if (k == 3) begin kind = 0; fw = 199; end
      else begin
        kind = $urandom_range(0, 5);
        fw = $urandom_range(0, 4);
        mw = $urandom_range(0, 4);
        tk = 1'($urandom);
      end
      rrun = (k >= 4);
      {rw, mr, ms, br, jp} = 5'b0;
      case (kind)
        0: rw = 1;
        1: begin rw = 1; mr = 1; end
        2: ms = 1;
        3: br = 1;
        4: begin rw = 1; jp = 1; end
        default: jp = 1;
      endcase
      if (m_idle) begin
        run = 1'b1;
        trap_clr = 1'($urandom);
        mem_ready = 1'($urandom);
        #1;
        total++;
        if ({state, mem_req, pc_en, rf_we, trap}
            !== 7'd0) begin
          bad++;
          $display("FAIL idle_start st=%0d exp=0", state);
        end
        tick();
      end
      q.delete();
      for (int i = 0; i <= fw; i++) begin
        c = '{default: 0};
        c.st = 3'd1;
        c.req = 1;
        c.rdy = (i == fw);
        c.ir = (i == fw);
        q.push_back(c);
      end
      c = '{default: 0};
      c.st = 3'd2;
      c.rdy = 1'($urandom);
      q.push_back(c);
      c = '{default: 0};
      c.st = 3'd3;
      c.rdy = 1'($urandom);
      if (!mr && !ms && !rw) begin
        c.pce = 1;
        c.pcs = (br && tk) || jp;
      end
      q.push_back(c);
      if (mr || ms) begin
        for (int i = 0; i <= mw; i++) begin
          c = '{default: 0};
          c.st = 3'd4;
          c.req = 1;
          c.as = 1;
          c.we = ms;
          c.rdy = (i == mw);
          c.mdr = (i == mw) && !ms;
          c.pce = (i == mw) && ms;
          q.push_back(c);
        end
      end
      if ((mr && !ms) || (!mr && !ms && rw)) begin
        c = '{default: 0};
        c.st = 3'd5;
        c.rdy = 1'($urandom);
        c.rfw = 1;
        c.pce = 1;
        c.pcs = jp;
        q.push_back(c);
      end
      lrun = 1'b1;
      for (int i = 0; i < q.size(); i++) begin
        c = q[i];
        mem_ready = c.rdy;
        branch_taken = (c.st == 3'd3) ? tk : 1'($urandom);
        trap_clr = 1'($urandom);
        if (c.st == 3'd2) begin
          {reg_write, mem_read, mem_write} = {rw, mr, ms};
          {branch, jump} = {br, jp};
          {illegal, is_system} = 2'b00;
        end else begin
          {reg_write, mem_read, mem_write, branch, jump,
           illegal, is_system} = 7'($urandom);
        end
        if (k == 39) run = 1'b0;
        else if (rrun) run = ($urandom_range(0, 3) != 0);
        else run = 1'b1;
        lrun = run;
        #1;
        got = {state, ir_en, mdr_en, pc_en, pc_sel, mem_req,
               mem_we, addr_sel, rf_we, trap, trap_cause};
        exp = {c.st, c.ir, c.mdr, c.pce, c.pcs, c.req,
               c.we, c.as, c.rfw, 1'b0, 2'b00};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL cycle k=%0d i=%0d got=%b exp=%b",
                   k, i, got, exp);
        end
        tick();
      end
      m_instret++;
      m_idle = !lrun;
      total++;
      if (instret !== m_instret) begin
        bad++;
        $display("FAIL instret k=%0d got=%0d exp=%0d",
                 k, instret, m_instret);
      end
    end
    {illegal, is_system} = 2'b00;
    trap_clr = 1'b0;
  endtask

  task automatic test_traps();
    bit ill, sys;
    logic [1:0] ec;
    for (int t = 0; t < 3; t++) begin
      ill = (t != 1);
      sys = (t != 0);
      ec = ill ? 2'b01 : 2'b11;
      run = 1'b1;
      trap_clr = 1'b0;
      mem_ready = 1'b0;
      tick();
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'($urandom);
      {reg_write, mem_read, mem_write, branch, jump} =
        5'($urandom);
      illegal = ill;
      is_system = sys;
      #1;
      total++;
      if (state !== 3'd2) begin
        bad++;
        $display("FAIL trap_decode st=%0d exp=2", state);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        run = 1'($urandom);
        mem_ready = 1'($urandom);
        {illegal, is_system} = 2'b00;
        #1;
        total++;
        if ({state, trap, trap_cause, mem_req, pc_en, rf_we,
             ir_en} !== {3'd6, 1'b1, ec, 4'b0}) begin
          bad++;
          $display("FAIL trap_hold t=%0d st=%0d cause=%b exp=%b",
                   t, state, trap_cause, ec);
        end
        tick();
      end
      total++;
      if (instret !== m_instret) begin
        bad++;
        $display("FAIL trap_instret got=%0d exp=%0d",
                 instret, m_instret);
      end
      trap_clr = 1'b1;
      run = 1'b0;
      tick();
      trap_clr = 1'b0;
      #1;
      total++;
      if ({state, trap, trap_cause} !== 6'd0) begin
        bad++;
        $display("FAIL trap_clear st=%0d cause=%b exp 0/00",
                 state, trap_cause);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int waits;
    logic [2:0] ws;
    for (int w = 0; w < 2; w++) begin
      ws = (w != 0) ? 3'd4 : 3'd1;
      {reg_write, mem_read, mem_write, branch, jump} = 5'b0;
      run = 1'b1;
      mem_ready = 1'b0;
      trap_clr = 1'b0;
      tick();
      if (w != 0) begin
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_read = 1'b1;
        reg_write = 1'b1;
        tick();
        mem_read = 1'b0;
        reg_write = 1'b0;
        tick();
      end
      waits = 0;
      #1;
      while (state == ws && waits < 400) begin
        waits++;
        tick();
        #1;
      end
      total++;
      if (waits != 200) begin
        bad++;
        $display("FAIL timeout_waits w=%0d got=%0d exp=200",
                 w, waits);
      end
      total++;
      if ({state, trap_cause} !== {3'd6, 2'b10}) begin
        bad++;
        $display("FAIL timeout_trap st=%0d cause=%b exp 6/10",
                 state, trap_cause);
      end
      total++;
      if (instret !== m_instret) begin
        bad++;
        $display("FAIL timeout_instret got=%0d exp=%0d",
                 instret, m_instret);
      end
      trap_clr = 1'b1;
      run = 1'b0;
      @(negedge clk);
      tick();
      trap_clr = 1'b0;
    end
  endtask

  task automatic test_reset_mid_mem();
    run = 1'b1;
    mem_ready = 1'b0;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    tick();
    tick();
    #1;
    total++;
    if ({state, mem_req, mem_we, addr_sel} !== 6'b100111) begin
      bad++;
      $display("FAIL mem_pre st=%0d req=%b exp 4/1",
               state, mem_req);
    end
    rst_n = 1'b0;
    #1;
    m_instret = '0;
    total++;
    if ({mem_req, state, trap_cause, pc_en} !== 7'd0 ||
        instret !== m_instret) begin
      bad++;
      $display("FAIL reset_mid_mem req=%b st=%0d ret=%0d",
               mem_req, state, instret);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    m_instret = 32'hFFFF_FFFF;
    run = 1'b1;
    @(negedge clk);
    mem_ready = 1'b1;
    tick();
    {reg_write, mem_read, mem_write, branch, jump} = 5'b00010;
    tick();
    branch_taken = 1'b1;
    run = 1'b0;
    #1;
    total++;
    if ({pc_en, pc_sel, rf_we} !== 3'b110) begin
      bad++;
      $display("FAIL beq_exec got=%b exp=110",
               {pc_en, pc_sel, rf_we});
    end
    tick();
    m_instret++;
    total++;
    if (instret !== m_instret || state !== 3'd0) begin
      bad++;
      $display("FAIL wrap got=%h st=%0d exp=%h st=0",
               instret, state, m_instret);
    end
  endtask

  initial begin
    test_reset();
    test_instr_stream();
    test_traps();
    test_timeout();
    test_reset_mid_mem();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
